// File: rtl/buffer_unpacker.sv
// Pops WIDTH-bit words from the circular buffer and streams OUT_WIDTH slices.
// Optional words_sent counter enabled by BUFFER_UNPACKER_CNT_EN.
module buffer_unpacker #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buf_empty,
  output logic                 buf_rd,
  input  logic [WIDTH-1:0]     buf_data,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef BUFFER_UNPACKER_CNT_EN
  ,
  output logic [15:0]          words_sent
`endif
);

  localparam int N    = WIDTH / OUT_WIDTH;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 buf_rd_q, buf_rd_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [WIDTH-1:0]     sh_next;
  logic                 xfer;
  logic                 last_xfer;

  function automatic logic [OUT_WIDTH-1:0] head(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1 -: OUT_WIDTH];
    return w[OUT_WIDTH-1:0];
  endfunction

  // The register shifts toward the output end so the next slice is always at the head.
  always_comb begin
    if (MSB_FIRST != 0) sh_next = sh_q << OUT_WIDTH;
    else                sh_next = sh_q >> OUT_WIDTH;
  end

  assign xfer      = out_valid_q & out_ready;
  assign last_xfer = (state_q == SEND) & xfer & (idx_q == LAST);

  always_comb begin
    state_d     = state_q;
    buf_rd_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    unique case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          buf_rd_d = 1'b1;
          state_d  = RD;
        end
      end
      RD: begin
        state_d = LOAD;
      end
      LOAD: begin
        sh_d        = buf_data;
        idx_d       = '0;
        out_data_d  = head(buf_data);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            idx_d      = idx_q + 1'b1;
            sh_d       = sh_next;
            out_data_d = head(sh_next);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
    end else begin
      state_q     <= state_d;
      buf_rd_q    <= buf_rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
    end
  end

  assign buf_rd    = buf_rd_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

`ifdef BUFFER_UNPACKER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (last_xfer) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign words_sent = cnt_q;
`else
  logic unused_last;
  assign unused_last = last_xfer;
`endif

endmodule

// File: tb/tb_buffer_unpacker.sv
// Scoreboard bench for buffer_unpacker: LSB-first and MSB-first instances.
// Each instance is fed by a small queue model of the circular buffer.
module tb_buffer_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_empty = 1'b1, a_rd, a_valid, a_ready = 1'b0, a_busy;
  logic [31:0] a_data = '0;
  logic [7:0]  a_out;
  logic        b_empty = 1'b1, b_rd, b_valid, b_ready = 1'b0, b_busy;
  logic [31:0] b_data = '0;
  logic [7:0]  b_out;
`ifdef BUFFER_UNPACKER_CNT_EN
  logic [15:0] a_ws, b_ws;
`endif

  bit [31:0] a_q[$], b_q[$];
  bit [7:0]  a_exp[$], b_exp[$], a_obs[$], b_obs[$];
  int        a_rds = 0, b_rds = 0;
  int        checks = 0, errors = 0;

  always #5 clk = ~clk;

  buffer_unpacker #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .buf_empty(a_empty), .buf_rd(a_rd),
    .buf_data(a_data), .out_data(a_out), .out_valid(a_valid),
    .out_ready(a_ready), .busy(a_busy)
`ifdef BUFFER_UNPACKER_CNT_EN
    , .words_sent(a_ws)
`endif
  );

  buffer_unpacker #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .buf_empty(b_empty), .buf_rd(b_rd),
    .buf_data(b_data), .out_data(b_out), .out_valid(b_valid),
    .out_ready(b_ready), .busy(b_busy)
`ifdef BUFFER_UNPACKER_CNT_EN
    , .words_sent(b_ws)
`endif
  );

  // Buffer models: pop on the read strobe, data visible the next cycle.
  always @(posedge clk) begin
    if (a_rd && a_q.size() != 0) a_data <= a_q.pop_front();
    a_empty <= (a_q.size() == 0);
    if (b_rd && b_q.size() != 0) b_data <= b_q.pop_front();
    b_empty <= (b_q.size() == 0);
  end

  // Collect slices that will transfer on the coming edge.
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) a_obs.push_back(a_out);
    if (!rst && b_valid && b_ready) b_obs.push_back(b_out);
    if (a_rd) a_rds++;
    if (b_rd) b_rds++;
  end

  task automatic push_a(input bit [31:0] w);
    a_q.push_back(w);
    a_empty = 1'b0;
    for (int i = 0; i < 4; i++) a_exp.push_back(w[8*i +: 8]);
  endtask

  task automatic push_b(input bit [31:0] w);
    b_q.push_back(w);
    b_empty = 1'b0;
    for (int i = 0; i < 4; i++) b_exp.push_back(w[31-8*i -: 8]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (a_valid !== 1'b0 || a_rd !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got v=%b rd=%b busy=%b want 0 0 0", a_valid, a_rd, a_busy);
    end
    checks++;
    if (a_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", a_out);
    end
    checks++;
    if (b_valid !== 1'b0 || b_rd !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_msb got v=%b rd=%b busy=%b want 0 0 0", b_valid, b_rd, b_busy);
    end
`ifdef BUFFER_UNPACKER_CNT_EN
    checks++;
    if (a_ws !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", a_ws);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_empty();
    int rd0;
    rd0 = a_rds;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (a_rd !== 1'b0 || a_valid !== 1'b0 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle cyc %0d got rd=%b v=%b busy=%b want 0 0 0",
                 i, a_rd, a_valid, a_busy);
      end
    end
    checks++;
    if (a_rds != rd0) begin
      errors++;
      $display("FAIL empty_rds got %0d want 0", a_rds - rd0);
    end
  endtask

  task automatic test_lsb();
    int rd0;
    bit [7:0] got, want;
    rd0 = a_rds;
    a_ready = 1'b1;
    push_a(32'h0000_0069);
    push_a(32'h0000_0420);
    for (int c = 0; c < 100 && a_exp.size() != 0; c++) begin
      step();
      while (a_obs.size() != 0 && a_exp.size() != 0) begin
        got = a_obs.pop_front();
        want = a_exp.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL lsb_slice got %h want %h", got, want);
        end
      end
    end
    checks++;
    if (a_exp.size() != 0) begin
      errors++;
      $display("FAIL lsb_timeout got %0d pending want 0", a_exp.size());
    end
    repeat (3) step();
    checks++;
    if (a_rds - rd0 != 2 || a_busy !== 1'b0 || a_obs.size() != 0) begin
      errors++;
      $display("FAIL lsb_end got rds=%0d busy=%b extra=%0d want 2 0 0",
               a_rds - rd0, a_busy, a_obs.size());
    end
  endtask

  task automatic test_msb();
    bit [7:0] got, want;
    b_ready = 1'b1;
    push_b(32'h1234_5678);
    step();
    checks++;
    if (b_rd !== 1'b1) begin
      errors++;
      $display("FAIL msb_rd_cyc1 got %b want 1", b_rd);
    end
    step();
    checks++;
    if (b_valid !== 1'b0) begin
      errors++;
      $display("FAIL msb_valid_cyc2 got %b want 0", b_valid);
    end
    step();
    checks++;
    if (b_valid !== 1'b1) begin
      errors++;
      $display("FAIL msb_valid_cyc3 got %b want 1", b_valid);
    end
    for (int c = 0; c < 100 && b_exp.size() != 0; c++) begin
      step();
      while (b_obs.size() != 0 && b_exp.size() != 0) begin
        got = b_obs.pop_front();
        want = b_exp.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL msb_slice got %h want %h", got, want);
        end
      end
    end
    checks++;
    if (b_exp.size() != 0) begin
      errors++;
      $display("FAIL msb_timeout got %0d pending want 0", b_exp.size());
    end
  endtask

  task automatic test_backpressure();
    bit [7:0] got, want;
    a_ready = 1'b0;
    push_a(32'h0000_0260);
    for (int c = 0; c < 20 && !a_valid; c++) step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_valid !== 1'b1 || a_out !== 8'h60) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b d=%h want 1 60", i, a_valid, a_out);
      end
      step();
    end
    a_ready = 1'b1;
    for (int c = 0; c < 100 && a_exp.size() != 0; c++) begin
      step();
      while (a_obs.size() != 0 && a_exp.size() != 0) begin
        got = a_obs.pop_front();
        want = a_exp.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL bp_slice got %h want %h", got, want);
        end
      end
    end
    checks++;
    if (a_exp.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout got %0d pending want 0", a_exp.size());
    end
  endtask

  task automatic test_reset_mid();
    bit [7:0] got, want;
    a_ready = 1'b1;
    a_q.push_back(32'h0000_0124);
    a_empty = 1'b0;
    for (int c = 0; c < 20 && a_obs.size() == 0; c++) step();
    rst = 1'b1;
    step();
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got v=%b busy=%b want 0 0", a_valid, a_busy);
    end
    rst = 1'b0;
    checks++;
    got = (a_obs.size() != 0) ? a_obs.pop_front() : 8'hxx;
    if (got !== 8'h24) begin
      errors++;
      $display("FAIL rstmid_first got %h want 24", got);
    end
    repeat (10) step();
    checks++;
    if (a_obs.size() != 0) begin
      errors++;
      $display("FAIL rstmid_leak got %0d slices want 0", a_obs.size());
    end
    push_a(32'h0000_0069);
    for (int c = 0; c < 100 && a_exp.size() != 0; c++) begin
      step();
      while (a_obs.size() != 0 && a_exp.size() != 0) begin
        got = a_obs.pop_front();
        want = a_exp.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL rstmid_next got %h want %h", got, want);
        end
      end
    end
    checks++;
    if (a_exp.size() != 0) begin
      errors++;
      $display("FAIL rstmid_timeout got %0d pending want 0", a_exp.size());
    end
  endtask

  task automatic test_back_to_back();
    int rd0;
    bit [7:0] got, want;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd0 = a_rds;
    a_ready = 1'b1;
    push_a(32'hA1B2_C3D4);
    push_a(32'h0F0E_0D0C);
    push_a(32'hFFFF_0001);
    for (int c = 0; c < 200 && a_exp.size() != 0; c++) begin
      step();
      while (a_obs.size() != 0 && a_exp.size() != 0) begin
        got = a_obs.pop_front();
        want = a_exp.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_slice got %h want %h", got, want);
        end
      end
    end
    checks++;
    if (a_exp.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout got %0d pending want 0", a_exp.size());
    end
    repeat (3) step();
    checks++;
    if (a_rds - rd0 != 3) begin
      errors++;
      $display("FAIL b2b_rds got %0d want 3", a_rds - rd0);
    end
`ifdef BUFFER_UNPACKER_CNT_EN
    checks++;
    if (a_ws !== 16'd3) begin
      errors++;
      $display("FAIL cnt_words got %0d want 3", a_ws);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (a_ws !== 16'd0) begin
      errors++;
      $display("FAIL cnt_reset got %0d want 0", a_ws);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_empty();
    test_lsb();
    test_msb();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
